countdown_timer: RTL and testbench

- Counts down from a loaded BCD preset MM:SS.th to 00:00.00 at 100 Hz and flags expiry.
- Mirror of the stopwatch (count-down rather than count-up), on the same board, with the same buttons, seven-segment outputs and 100 Hz indicator.
- Buttons are active-low and asynchronous to the clock; the block synchronises them itself.

---
 rtl/countdown_timer_pkg.sv | 42 ++++
 rtl/countdown_timer_bcd_to_seven_seg.sv | 17 +
 rtl/countdown_timer.sv | 202 ++++++++++++++++++++
 tb/tb_countdown_timer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer: state encoding, digit width,
// seven-segment patterns and small per-digit helpers.
package countdown_timer_pkg;

    localparam int DIGIT_W         = 4;
    localparam int NUM_DIGITS      = 6;
    localparam int DEFAULT_CLK_DIV = 500000;   // 50 MHz down to 100 Hz

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    // Active-low {g,f,e,d,c,b,a}; element n is the glyph for digit n.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0010000,   // 9
        7'b0000000,   // 8
        7'b1111000,   // 7
        7'b0000010,   // 6
        7'b0010010,   // 5
        7'b0011001,   // 4
        7'b0110000,   // 3
        7'b0100100,   // 2
        7'b1111001,   // 1
        7'b1000000    // 0
    };
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Largest legal value of digit position idx (0 = hundredths ... 5 = ten_mins).
    function automatic logic [DIGIT_W-1:0] digit_max(input int idx);
        return (idx == 3) ? 4'd5 : 4'd9;
    endfunction

    function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d,
                                                       input logic [DIGIT_W-1:0] max_val);
        return (d > max_val) ? max_val : d;
    endfunction

endpackage

// File: rtl/countdown_timer_bcd_to_seven_seg.sv
// BCD digit to active-low seven-segment decoder; non-decimal codes blank the digit.
module bcd_to_seven_seg
    import countdown_timer_pkg::*;
(
    input  logic [DIGIT_W-1:0] bcd,
    output logic [6:0]         seg
);

    // Table lookup for 0-9, blank otherwise.
    always_comb begin
        seg = SEG_BLANK;
        if (bcd <= 4'd9) begin
            seg = SEG_TABLE[bcd];
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// MM:SS.th countdown timer: loads a BCD preset, counts down at 100 Hz,
// flags expiry, and drives six active-low seven-segment digits.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
)
(
    input  logic        CLK_50MHz,
    input  logic        reset,
    input  logic        start_stop,
    input  logic        load,
    input  logic        hold,
    input  logic [23:0] preset_bcd,
    output logic [6:0]  ten_mins_seven_seg,
    output logic [6:0]  one_min_seven_seg,
    output logic [6:0]  ten_secs_seven_seg,
    output logic [6:0]  one_sec_seven_seg,
    output logic [6:0]  tenths_seven_seg,
    output logic [6:0]  hundredths_seven_seg,
    output logic        CLK_ind,
    output logic        expired_flag
);

    localparam int              DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam int              CNT_W    = DIGIT_W * NUM_DIGITS;

    // ---------------- input conditioning ----------------
    logic [2:0] btn_raw;
    logic [2:0] sync1_reg, sync2_reg;
    logic [1:0] prev_reg, fall_reg;
    logic       start_press, load_press, hold_sync;

    assign btn_raw     = {hold, load, start_stop};
    assign start_press = fall_reg[0];
    assign load_press  = fall_reg[1];
    assign hold_sync   = sync2_reg[2];

    // Two-flop synchronisers plus a registered falling-edge detector for the buttons.
    always_ff @(posedge CLK_50MHz or posedge reset) begin
        if (reset) begin
            sync1_reg <= '1;
            sync2_reg <= '1;
            prev_reg  <= '1;
            fall_reg  <= '0;
        end else begin
            sync1_reg <= btn_raw;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg[1:0];
            fall_reg  <= prev_reg & ~sync2_reg[1:0];
        end
    end

    // ---------------- 100 Hz divider ----------------
    logic [DIV_W-1:0] div_reg, div_next;
    logic             tick;
    logic             clk_ind_reg;

    assign tick     = (div_reg == DIV_LAST);
    assign div_next = tick ? '0 : div_reg + 1'b1;

    // Free-running divider; the indicator tracks the phase the divider is entering.
    always_ff @(posedge CLK_50MHz or posedge reset) begin
        if (reset) begin
            div_reg     <= '0;
            clk_ind_reg <= 1'b0;
        end else begin
            div_reg     <= div_next;
            clk_ind_reg <= (div_next < DIV_HALF);
        end
    end

    // ---------------- count arithmetic ----------------
    logic [CNT_W-1:0]      count_reg, count_next;
    logic [CNT_W-1:0]      dec_count, clamped_preset;
    logic [NUM_DIGITS-1:0] borrow;

    assign borrow[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [DIGIT_W-1:0] cur;
            assign cur = count_reg[gi*DIGIT_W +: DIGIT_W];
            // Ripple borrow: a zero digit wraps to its maximum and borrows upward.
            assign dec_count[gi*DIGIT_W +: DIGIT_W] =
                borrow[gi] ? ((cur == '0) ? digit_max(gi) : cur - 1'b1) : cur;
            assign clamped_preset[gi*DIGIT_W +: DIGIT_W] =
                clamp_digit(preset_bcd[gi*DIGIT_W +: DIGIT_W], digit_max(gi));
            if (gi < NUM_DIGITS - 1) begin : g_borrow
                assign borrow[gi+1] = borrow[gi] & (cur == '0);
            end
        end
    endgenerate

    // ---------------- control FSM ----------------
    state_t state_reg, state_next;

    // State and live count registers.
    always_ff @(posedge CLK_50MHz or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    // Next state and count; load outranks start wherever load is honoured.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        case (state_reg)
            IDLE: begin
                if (load_press) begin
                    count_next = clamped_preset;
                end else if (start_press && (count_reg != '0)) begin
                    state_next = RUNNING;
                end
            end
            RUNNING: begin
                if (tick) begin
                    count_next = dec_count;
                end
                if (tick && (dec_count == '0)) begin
                    state_next = EXPIRED;
                end else if (start_press) begin
                    state_next = PAUSED;
                end
            end
            PAUSED: begin
                if (load_press) begin
                    count_next = clamped_preset;
                    state_next = IDLE;
                end else if (start_press) begin
                    state_next = RUNNING;
                end
            end
            EXPIRED: begin
                if (load_press) begin
                    count_next = clamped_preset;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    logic [CNT_W-1:0] snap_reg, snap_next;
    logic             expired_next;
    logic             expired_reg;

    // Display snapshot follows the new count unless hold freezes it.
    always_comb begin
        expired_next = (state_reg == EXPIRED);
        snap_next    = hold_sync ? count_next : snap_reg;
    end

    // Registered expiry flag and display snapshot.
    always_ff @(posedge CLK_50MHz or posedge reset) begin
        if (reset) begin
            expired_reg <= 1'b0;
            snap_reg    <= '0;
        end else begin
            expired_reg <= expired_next;
            snap_reg    <= snap_next;
        end
    end

    logic [6:0] seg_dec [NUM_DIGITS];
    logic [6:0] seg_reg [NUM_DIGITS];

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_seg
            bcd_to_seven_seg u_dec (
                .bcd (snap_reg[gi*DIGIT_W +: DIGIT_W]),
                .seg (seg_dec[gi])
            );
            // Register each decoded digit for glitch-free segment drive.
            always_ff @(posedge CLK_50MHz or posedge reset) begin
                if (reset) begin
                    seg_reg[gi] <= SEG_ZERO;
                end else begin
                    seg_reg[gi] <= seg_dec[gi];
                end
            end
        end
    endgenerate

    assign hundredths_seven_seg = seg_reg[0];
    assign tenths_seven_seg     = seg_reg[1];
    assign one_sec_seven_seg    = seg_reg[2];
    assign ten_secs_seven_seg   = seg_reg[3];
    assign one_min_seven_seg    = seg_reg[4];
    assign ten_mins_seven_seg   = seg_reg[5];
    assign CLK_ind              = clk_ind_reg;
    assign expired_flag         = expired_reg;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: a centisecond-level behavioural
// model is compared against every output on every falling clock edge.
module tb_countdown_timer;

    localparam int CLK_DIV = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_stop = 1'b1;
    logic        load = 1'b1;
    logic        hold = 1'b1;
    logic [23:0] preset_bcd = '0;
    logic [6:0]  ten_mins_seven_seg, one_min_seven_seg, ten_secs_seven_seg;
    logic [6:0]  one_sec_seven_seg, tenths_seven_seg, hundredths_seven_seg;
    logic        CLK_ind, expired_flag;

    always #10 clk = ~clk;

    countdown_timer #(.CLK_DIV(CLK_DIV)) dut (
        .CLK_50MHz            (clk),
        .reset                (reset),
        .start_stop           (start_stop),
        .load                 (load),
        .hold                 (hold),
        .preset_bcd           (preset_bcd),
        .ten_mins_seven_seg   (ten_mins_seven_seg),
        .one_min_seven_seg    (one_min_seven_seg),
        .ten_secs_seven_seg   (ten_secs_seven_seg),
        .one_sec_seven_seg    (one_sec_seven_seg),
        .tenths_seven_seg     (tenths_seven_seg),
        .hundredths_seven_seg (hundredths_seven_seg),
        .CLK_ind              (CLK_ind),
        .expired_flag         (expired_flag)
    );

    logic [6:0] dut_seg [6];
    assign dut_seg[0] = hundredths_seven_seg;
    assign dut_seg[1] = tenths_seven_seg;
    assign dut_seg[2] = one_sec_seven_seg;
    assign dut_seg[3] = ten_secs_seven_seg;
    assign dut_seg[4] = one_min_seven_seg;
    assign dut_seg[5] = ten_mins_seven_seg;

    int n_checks = 0;
    int n_err    = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {M_STOPPED, M_COUNTING, M_FROZEN, M_DONE} mstate_t;

    mstate_t    m_state;
    int         m_cnt;      // live count in centiseconds
    int         m_snap;     // displayed count in centiseconds
    int         m_div;
    bit         m_flag, m_ind;
    logic [6:0] m_seg [6];
    bit [4:0]   h_ss, h_ld, h_hd;   // [0] = sample at this edge, [n] = n edges earlier

    function automatic logic [6:0] pat(input int d);
        logic [6:0] t [0:9];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return t[d];
    endfunction

    function automatic int digit_of(input int cs, input int idx);
        case (idx)
            0: return cs % 10;
            1: return (cs / 10) % 10;
            2: return (cs / 100) % 10;
            3: return (cs % 6000) / 1000;
            4: return (cs / 6000) % 10;
            default: return cs / 60000;
        endcase
    endfunction

    function automatic int preset_to_cs(input logic [23:0] p);
        int d [6];
        for (int i = 0; i < 6; i++) begin
            d[i] = int'(p[i*4 +: 4]);
            if (d[i] > 9) d[i] = 9;
        end
        if (d[3] > 5) d[3] = 5;
        return (d[5] * 10 + d[4]) * 6000 + (d[3] * 10 + d[2]) * 100 + d[1] * 10 + d[0];
    endfunction

    task automatic model_init();
        m_state = M_STOPPED;
        m_cnt   = 0;
        m_snap  = 0;
        m_div   = 0;
        m_flag  = 1'b0;
        m_ind   = 1'b0;
        h_ss    = '1;
        h_ld    = '1;
        h_hd    = '1;
        for (int i = 0; i < 6; i++) m_seg[i] = pat(0);
    endtask

    task automatic model_step();
        bit      st, ld, hold_on, tick;
        mstate_t old_state;
        int      old_snap;
        h_ss    = {h_ss[3:0], start_stop};
        h_ld    = {h_ld[3:0], load};
        h_hd    = {h_hd[3:0], hold};
        st      = !h_ss[3] && h_ss[4];
        ld      = !h_ld[3] && h_ld[4];
        hold_on = !h_hd[2];
        tick    = (m_div == CLK_DIV - 1);
        old_state = m_state;
        old_snap  = m_snap;
        case (m_state)
            M_STOPPED: begin
                if (ld) m_cnt = preset_to_cs(preset_bcd);
                else if (st && m_cnt != 0) m_state = M_COUNTING;
            end
            M_COUNTING: begin
                if (tick) m_cnt = m_cnt - 1;
                if (m_cnt == 0) m_state = M_DONE;
                else if (st) m_state = M_FROZEN;
            end
            M_FROZEN: begin
                if (ld) begin
                    m_cnt = preset_to_cs(preset_bcd);
                    m_state = M_STOPPED;
                end else if (st) m_state = M_COUNTING;
            end
            default: begin
                if (ld) begin
                    m_cnt = preset_to_cs(preset_bcd);
                    m_state = M_STOPPED;
                end
            end
        endcase
        m_flag = (old_state == M_DONE);
        for (int i = 0; i < 6; i++) m_seg[i] = pat(digit_of(old_snap, i));
        if (!hold_on) m_snap = m_cnt;
        m_div = (m_div + 1) % CLK_DIV;
        m_ind = (m_div < CLK_DIV / 2);
    endtask

    initial begin
        model_init();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_init();
            else model_step();
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                for (int i = 0; i < 6; i++)
                    chk($sformatf("seg%0d", i), int'(dut_seg[i]), int'(m_seg[i]));
                chk("clk_ind", int'(CLK_ind), int'(m_ind));
                chk("expired_flag", int'(expired_flag), int'(m_flag));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input bit s, input bit l, input int len);
        @(negedge clk);
        if (s) start_stop = 1'b0;
        if (l) load = 1'b0;
        repeat (len) @(negedge clk);
        start_stop = 1'b1;
        load = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_all_segs(input string name, input logic [6:0] e5, input logic [6:0] e4,
                                input logic [6:0] e3, input logic [6:0] e2,
                                input logic [6:0] e1, input logic [6:0] e0);
        chk({name, "_tm"}, int'(ten_mins_seven_seg), int'(e5));
        chk({name, "_om"}, int'(one_min_seven_seg), int'(e4));
        chk({name, "_ts"}, int'(ten_secs_seven_seg), int'(e3));
        chk({name, "_os"}, int'(one_sec_seven_seg), int'(e2));
        chk({name, "_te"}, int'(tenths_seven_seg), int'(e1));
        chk({name, "_hu"}, int'(hundredths_seven_seg), int'(e0));
    endtask

    localparam logic [6:0] P0 = 7'b1000000;
    localparam logic [6:0] P2 = 7'b0100100;
    localparam logic [6:0] P3 = 7'b0110000;
    localparam logic [6:0] P5 = 7'b0010010;
    localparam logic [6:0] P9 = 7'b0010000;

    initial begin
        // Reset state
        #5 reset = 1'b1;
        #30;
        chk_all_segs("reset", P0, P0, P0, P0, P0, P0);
        chk("reset_ind", int'(CLK_ind), 0);
        chk("reset_flag", int'(expired_flag), 0);
        cmp_en = 1'b1;
        @(negedge clk) reset = 1'b0;

        // Load 00:00.05, run to expiry
        preset_bcd = 24'h000005;
        push(0, 1, 2);
        cyc(6);
        chk("load5_hu", int'(hundredths_seven_seg), int'(P5));
        push(1, 0, 2);
        cyc(30);
        chk("expire_flag", int'(expired_flag), 1);
        chk("expire_hu", int'(hundredths_seven_seg), int'(P0));

        // Borrow chain from 10:00.00
        preset_bcd = 24'h100000;
        push(0, 1, 2);
        cyc(6);
        push(1, 0, 2);
        cyc(8);
        chk("borrow_tm", int'(ten_mins_seven_seg), int'(P0));
        chk("borrow_om", int'(one_min_seven_seg), int'(P9));
        chk("borrow_ts", int'(ten_secs_seven_seg), int'(P5));

        // Pause/resume, then load while running is ignored
        push(1, 0, 2);
        cyc(40);
        push(1, 0, 2);
        cyc(12);
        preset_bcd = 24'h000111;
        push(0, 1, 2);
        cyc(10);
        chk("run_load_ignored_ts", int'(ten_secs_seven_seg), int'(P5));

        // Hold at 00:03.00 while counting
        push(1, 0, 2);
        preset_bcd = 24'h000300;
        push(0, 1, 2);
        cyc(6);
        hold = 1'b0;
        cyc(3);
        push(1, 0, 2);
        cyc(36);
        chk_all_segs("hold", P0, P0, P0, P3, P0, P0);
        hold = 1'b1;
        cyc(4);
        chk("hold_release_os", int'(one_sec_seven_seg), int'(P2));

        // Clamp, simultaneous load+start, start with zero count
        push(1, 0, 2);
        preset_bcd = 24'hFFFFFF;
        push(0, 1, 2);
        cyc(6);
        chk_all_segs("clamp", P9, P9, P5, P9, P9, P9);
        push(1, 1, 2);
        cyc(20);
        chk_all_segs("both", P9, P9, P5, P9, P9, P9);
        preset_bcd = 24'h000000;
        push(0, 1, 2);
        cyc(4);
        push(1, 0, 2);
        cyc(20);
        chk("zero_start_flag", int'(expired_flag), 0);
        chk("zero_start_hu", int'(hundredths_seven_seg), int'(P0));

        // Reset mid-run at 00:45.67
        preset_bcd = 24'h004567;
        push(0, 1, 2);
        cyc(4);
        push(1, 0, 2);
        cyc(10);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk_all_segs("midreset", P0, P0, P0, P0, P0, P0);
        chk("midreset_ind", int'(CLK_ind), 0);
        chk("midreset_flag", int'(expired_flag), 0);
        @(negedge clk) reset = 1'b0;
        @(negedge clk) chk("div_restart1", int'(CLK_ind), 1);
        @(negedge clk) chk("div_restart2", int'(CLK_ind), 0);
        @(negedge clk) chk("div_restart3", int'(CLK_ind), 0);
        @(negedge clk) chk("div_restart4", int'(CLK_ind), 1);

        // Randomised operation against the model
        for (int it = 0; it < 300; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 2) begin
                if ($urandom_range(0, 1) == 1)
                    preset_bcd = {16'h0, 4'($urandom_range(0, 2)), 4'($urandom_range(0, 9))};
                else
                    preset_bcd = 24'($urandom);
                push(0, 1, $urandom_range(1, 3));
            end else if (r <= 5) begin
                push(1, 0, $urandom_range(1, 3));
            end else if (r == 6) begin
                push(1, 1, $urandom_range(1, 3));
            end else if (r == 7) begin
                @(negedge clk) hold = ~hold;
            end else if (r == 8) begin
                push(1, 0, 0);
            end
            cyc($urandom_range(0, 25));
        end
        hold = 1'b1;
        cyc(5);
        cmp_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
